// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-hot active-low column drive, debounced
// press/release detection, hex encoding and a 4-nibble entry shift register.
module keypad_scanner #(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scan_tick,
    input  logic [3:0]  row,
    input  logic        clear,
    output logic [3:0]  col,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic [15:0] entry_value
);

    localparam logic [1:0] SCAN     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] HELD     = 2'd2;
    localparam logic [3:0] DT       = 4'(DEBOUNCE_TICKS);

    logic [3:0]  r1_q, rs_q;
    logic [1:0]  state_q, state_d;
    logic [1:0]  col_sel_q, col_sel_d;
    logic [1:0]  cand_row_q, cand_row_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  key_code_q, key_code_d;
    logic        key_valid_q, key_valid_d;
    logic [15:0] entry_q, entry_d;
    logic [1:0]  low_row;
    logic [3:0]  cnt_inc;
    logic        accept;

    function automatic logic [3:0] key_map(input logic [1:0] r,
                                           input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;
            4'h1: k = 4'h2;
            4'h2: k = 4'h3;
            4'h3: k = 4'hA;
            4'h4: k = 4'h4;
            4'h5: k = 4'h5;
            4'h6: k = 4'h6;
            4'h7: k = 4'hB;
            4'h8: k = 4'h7;
            4'h9: k = 4'h8;
            4'hA: k = 4'h9;
            4'hB: k = 4'hC;
            4'hC: k = 4'h0;
            4'hD: k = 4'hF;
            4'hE: k = 4'hE;
            default: k = 4'hD;
        endcase
        return k;
    endfunction

    // Lowest row index wins when several rows read low in one column.
    always_comb begin
        if (!rs_q[0])      low_row = 2'd0;
        else if (!rs_q[1]) low_row = 2'd1;
        else if (!rs_q[2]) low_row = 2'd2;
        else               low_row = 2'd3;
    end

    always_comb begin
        state_d     = state_q;
        col_sel_d   = col_sel_q;
        cand_row_d  = cand_row_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        entry_d     = entry_q;
        accept      = 1'b0;
        cnt_inc     = cnt_q + 4'd1;
        if (scan_tick) begin
            unique case (state_q)
                SCAN: begin
                    if (rs_q == 4'hF) begin
                        col_sel_d = col_sel_q + 2'd1;
                    end else begin
                        cand_row_d = low_row;
                        if (DT == 4'd1) begin
                            accept = 1'b1;
                        end else begin
                            cnt_d   = 4'd1;
                            state_d = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (rs_q[cand_row_q]) begin
                        state_d   = SCAN;
                        col_sel_d = col_sel_q + 2'd1;
                        cnt_d     = 4'd0;
                    end else if (cnt_inc == DT) begin
                        accept = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                HELD: begin
                    if (!rs_q[cand_row_q]) begin
                        cnt_d = 4'd0;
                    end else if (cnt_inc == DT) begin
                        state_d   = SCAN;
                        col_sel_d = col_sel_q + 2'd1;
                        cnt_d     = 4'd0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = SCAN;
                    cnt_d   = 4'd0;
                end
            endcase
        end
        if (accept) begin
            key_valid_d = 1'b1;
            key_code_d  = key_map(cand_row_d, col_sel_q);
            entry_d     = {entry_q[11:0], key_code_d};
            cnt_d       = 4'd0;
            state_d     = HELD;
        end
        if (clear) begin
            entry_d = 16'h0000;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r1_q        <= 4'hF;
            rs_q        <= 4'hF;
            state_q     <= SCAN;
            col_sel_q   <= 2'd0;
            cand_row_q  <= 2'd0;
            cnt_q       <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            entry_q     <= 16'h0000;
        end else begin
            r1_q        <= row;
            rs_q        <= r1_q;
            state_q     <= state_d;
            col_sel_q   <= col_sel_d;
            cand_row_q  <= cand_row_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            entry_q     <= entry_d;
        end
    end

    assign col         = ~(4'b0001 << col_sel_q);
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign entry_value = entry_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model drives rows from col,
// and a scoreboard queue holds expected (code, entry) for each accepted key.
module tb_keypad_scanner;

    localparam int DT = 4;

    typedef struct packed {
        logic [3:0]  code;
        logic [15:0] entry;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        scan_tick;
    logic [3:0]  row;
    logic        clear;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [15:0] entry_value;

    logic        pressed;
    logic [1:0]  kr, kc;
    logic [15:0] ev_m;
    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;

    keypad_scanner #(.DEBOUNCE_TICKS(DT)) dut (
        .clk(clk),
        .reset(reset),
        .scan_tick(scan_tick),
        .row(row),
        .clear(clear),
        .col(col),
        .key_code(key_code),
        .key_valid(key_valid),
        .entry_value(entry_value)
    );

    always #5 clk = ~clk;

    // Pressed key shorts its row to its column line.
    always_comb begin
        row = 4'b1111;
        if (pressed && col[kc] == 1'b0) row[kr] = 1'b0;
    end

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] col_of(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << c);
    endfunction

    task automatic tick(input logic clr, input logic exp_pulse,
                        input string tag);
        exp_t e;
        @(negedge clk);
        scan_tick = 1'b1;
        clear     = clr;
        @(negedge clk);
        scan_tick = 1'b0;
        clear     = 1'b0;
        chk({tag, "_valid"}, {15'd0, key_valid}, {15'd0, exp_pulse});
        if (key_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk({tag, "_unexpected"}, 16'd1, 16'd0);
            end else begin
                e = sb.pop_front();
                chk({tag, "_code"}, {12'd0, key_code}, {12'd0, e.code});
                chk({tag, "_entry"}, entry_value, e.entry);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic press_key(input int r, input int c,
                             input logic [3:0] code, input logic clr,
                             input int hold, input int rel);
        exp_t e;
        for (int i = 0; i < 8 && col !== col_of(c); i++)
            tick(1'b0, 1'b0, "seek");
        chk("seek_col", {12'd0, col}, {12'd0, col_of(c)});
        kr = 2'(r);
        kc = 2'(c);
        pressed = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 1; i <= hold; i++) begin
            if (i == DT) begin
                ev_m = clr ? 16'h0000 : {ev_m[11:0], code};
                e.code  = code;
                e.entry = ev_m;
                sb.push_back(e);
            end
            tick(clr && i == DT, i == DT, "hold");
        end
        chk("held_col", {12'd0, col}, {12'd0, col_of(c)});
        pressed = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 1; i <= rel; i++) begin
            tick(1'b0, 1'b0, "rel");
            if (i == DT - 1)
                chk("rel_hold_col", {12'd0, col}, {12'd0, col_of(c)});
            if (i == DT)
                chk("rel_resume_col", {12'd0, col},
                    {12'd0, col_of((c + 1) % 4)});
        end
        chk("sb_empty", 16'(sb.size()), 16'd0);
    endtask

    initial begin
        reset     = 1'b1;
        scan_tick = 1'b0;
        clear     = 1'b0;
        pressed   = 1'b0;
        kr        = 2'd0;
        kc        = 2'd0;
        ev_m      = 16'h0000;

        // reset / idle scanning
        repeat (3) @(negedge clk);
        chk("rst_col", {12'd0, col}, 16'h000E);
        chk("rst_code", {12'd0, key_code}, 16'h0000);
        chk("rst_valid", {15'd0, key_valid}, 16'h0000);
        chk("rst_entry", entry_value, 16'h0000);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b0, "idle");
            chk("idle_col", {12'd0, col}, {12'd0, col_of((i + 1) % 4)});
        end
        chk("idle_entry", entry_value, 16'h0000);

        // single press of 5
        press_key(1, 1, 4'h5, 1'b0, 10, 10);
        chk("single_entry", entry_value, 16'h0005);

        // bounce on key A
        for (int i = 0; i < 8 && col !== col_of(3); i++)
            tick(1'b0, 1'b0, "seek_b");
        chk("bounce_seek", {12'd0, col}, {12'd0, col_of(3)});
        kr = 2'd0;
        kc = 2'd3;
        pressed = 1'b1;
        repeat (3) @(negedge clk);
        tick(1'b0, 1'b0, "bounce1");
        tick(1'b0, 1'b0, "bounce2");
        pressed = 1'b0;
        repeat (3) @(negedge clk);
        tick(1'b0, 1'b0, "bounce_up");
        chk("bounce_scan_col", {12'd0, col}, 16'h000E);
        pressed = 1'b1;
        repeat (3) @(negedge clk);
        tick(1'b0, 1'b0, "bounce3");
        tick(1'b0, 1'b0, "bounce4");
        chk("bounce_adv_col", {12'd0, col}, {12'd0, col_of(2)});
        pressed = 1'b0;
        repeat (3) @(negedge clk);
        chk("bounce_entry", entry_value, 16'h0005);

        // entry and overflow
        press_key(0, 0, 4'h1, 1'b0, 5, 5);
        press_key(0, 1, 4'h2, 1'b0, 5, 5);
        press_key(0, 2, 4'h3, 1'b0, 5, 5);
        press_key(0, 3, 4'hA, 1'b0, 5, 5);
        chk("entry_123A", entry_value, 16'h123A);
        press_key(3, 3, 4'hD, 1'b0, 5, 5);
        chk("entry_23AD", entry_value, 16'h23AD);

        // clear colliding with acceptance
        press_key(3, 0, 4'h0, 1'b1, 5, 5);
        chk("clr_entry", entry_value, 16'h0000);
        press_key(2, 0, 4'h7, 1'b0, 5, 5);
        chk("after_clr_entry", entry_value, 16'h0007);

        // reset during debounce of key 9
        for (int i = 0; i < 8 && col !== col_of(2); i++)
            tick(1'b0, 1'b0, "seek_r");
        kr = 2'd2;
        kc = 2'd2;
        pressed = 1'b1;
        repeat (3) @(negedge clk);
        tick(1'b0, 1'b0, "pre_rst1");
        tick(1'b0, 1'b0, "pre_rst2");
        reset = 1'b1;
        #1;
        chk("mid_rst_col", {12'd0, col}, 16'h000E);
        chk("mid_rst_code", {12'd0, key_code}, 16'h0000);
        chk("mid_rst_valid", {15'd0, key_valid}, 16'h0000);
        chk("mid_rst_entry", entry_value, 16'h0000);
        ev_m = 16'h0000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        press_key(2, 2, 4'h9, 1'b0, 5, 5);
        chk("rst_entry_9", entry_value, 16'h0009);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
